// File: rtl/rv_pkg.sv
// Shared RV32I datapath constants: register file geometry and architectural register ids.
// Used by the register file, control unit, immediate generator and write-back mux.
package rv_pkg;
    localparam int XLEN   = 32;
    localparam int REG_AW = 5;
    localparam int NREG   = 32;

    localparam logic [REG_AW-1:0] REG_X0 = 5'd0;
    localparam logic [REG_AW-1:0] REG_SP = 5'd2;

    localparam logic [XLEN-1:0] SP_INIT_DEFAULT = 32'h0000_03FC;
endpackage

// File: rtl/reg_read_port.sv
// One combinational register-file read port with x0 forcing and optional write-first bypass.
// Zero latency; no flow control, the result is valid whenever the address is.
module reg_read_port #(
    parameter int XLEN      = 32,
    parameter int NREG      = 32,
    parameter int AW        = 5,
    parameter bit BYPASS_EN = 1'b1
) (
    input  logic [AW-1:0]                addr,
    input  logic [NREG-1:0][XLEN-1:0]    regs,
    input  logic                         byp_vld,
    input  logic [AW-1:0]                byp_addr,
    input  logic [XLEN-1:0]              byp_data,
    output logic [XLEN-1:0]              data
);
    always_comb begin
        data = regs[addr];
        if (addr == '0) begin
            data = '0;
        end else if (BYPASS_EN && byp_vld && (byp_addr == addr)) begin
            data = byp_data;
        end
    end
endmodule

// File: rtl/reg_file.sv
// RV32I integer register file: two operand read ports, one debug port, one write port.
// Reads are combinational, writes commit on the rising edge; no backpressure.
module reg_file
    import rv_pkg::*;
#(
    parameter int              XLEN    = rv_pkg::XLEN,
    parameter int              NREG    = rv_pkg::NREG,
    parameter int              AW      = rv_pkg::REG_AW,
    parameter logic [XLEN-1:0] SP_INIT = SP_INIT_DEFAULT,
    parameter int              BYPASS  = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [AW-1:0]   rs1_addr,
    input  logic [AW-1:0]   rs2_addr,
    input  logic [AW-1:0]   dbg_addr,
    input  logic [AW-1:0]   rd_addr,
    input  logic [XLEN-1:0] wr_data,
    input  logic            reg_write,
    output logic [XLEN-1:0] rs1_data,
    output logic [XLEN-1:0] rs2_data,
    output logic [XLEN-1:0] dbg_data,
    output logic [31:0]     wr_count
);
    // x0 has no storage; its slot in the read view is tied to zero.
    logic [XLEN-1:0]             regs [1:NREG-1];
    logic [NREG-1:0][XLEN-1:0]   view;
    logic [31:0]                 wr_cnt;
    logic                        wr_en;

    // Reset wins over a same-edge write, so such a write neither lands nor bypasses.
    assign wr_en    = reg_write && !rst && (rd_addr != '0);
    assign wr_count = wr_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 1; i < NREG; i++) begin
                regs[i] <= '0;
            end
            regs[REG_SP] <= SP_INIT;
            wr_cnt       <= '0;
        end else if (wr_en) begin
            regs[rd_addr] <= wr_data;
            wr_cnt        <= wr_cnt + 32'd1;
        end
    end

    always_comb begin
        view[0] = '0;
        for (int i = 1; i < NREG; i++) begin
            view[i] = regs[i];
        end
    end

    reg_read_port #(.XLEN(XLEN), .NREG(NREG), .AW(AW), .BYPASS_EN(BYPASS != 0)) u_rs1 (
        .addr     (rs1_addr),
        .regs     (view),
        .byp_vld  (wr_en),
        .byp_addr (rd_addr),
        .byp_data (wr_data),
        .data     (rs1_data)
    );

    reg_read_port #(.XLEN(XLEN), .NREG(NREG), .AW(AW), .BYPASS_EN(BYPASS != 0)) u_rs2 (
        .addr     (rs2_addr),
        .regs     (view),
        .byp_vld  (wr_en),
        .byp_addr (rd_addr),
        .byp_data (wr_data),
        .data     (rs2_data)
    );

    // Debug port shows committed state only, for end-of-test register dumps.
    reg_read_port #(.XLEN(XLEN), .NREG(NREG), .AW(AW), .BYPASS_EN(1'b0)) u_dbg (
        .addr     (dbg_addr),
        .regs     (view),
        .byp_vld  (1'b0),
        .byp_addr ('0),
        .byp_data ('0),
        .data     (dbg_data)
    );
endmodule

// File: tb/tb_reg_file.sv
// Scoreboard bench for reg_file: stimulus queues expected port values per cycle,
// a monitor pops and compares them mid-cycle on both a bypassing and a non-bypassing instance.
module tb_reg_file;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [4:0]  rs1_addr = '0, rs2_addr = '0, dbg_addr = '0, rd_addr = '0;
    logic [31:0] wr_data = '0;
    logic        reg_write = 1'b0;
    logic [31:0] rs1_data, rs2_data, dbg_data, wr_count;
    logic [31:0] rs1_nb, rs2_nb, dbg_nb, cnt_nb;

    always #5 clk = ~clk;

    reg_file dut (
        .clk(clk), .rst(rst), .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .dbg_addr(dbg_addr),
        .rd_addr(rd_addr), .wr_data(wr_data), .reg_write(reg_write),
        .rs1_data(rs1_data), .rs2_data(rs2_data), .dbg_data(dbg_data), .wr_count(wr_count)
    );

    reg_file #(.BYPASS(0)) dut_nb (
        .clk(clk), .rst(rst), .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .dbg_addr(dbg_addr),
        .rd_addr(rd_addr), .wr_data(wr_data), .reg_write(reg_write),
        .rs1_data(rs1_nb), .rs2_data(rs2_nb), .dbg_data(dbg_nb), .wr_count(cnt_nb)
    );

    typedef struct {
        int          id;
        bit          c1; logic [31:0] v1;
        bit          c2; logic [31:0] v2;
        bit          cd; logic [31:0] vd;
        bit          cc; logic [31:0] vc;
        bit          cn; logic [31:0] n1; logic [31:0] n2;
    } exp_t;

    exp_t q[$];
    int   n_chk  = 0;
    int   n_fail = 0;

    function automatic exp_t ex(input int id,
                                input bit c1, input logic [31:0] v1,
                                input bit c2, input logic [31:0] v2,
                                input bit cd, input logic [31:0] vd,
                                input bit cc, input logic [31:0] vc,
                                input bit cn, input logic [31:0] n1, input logic [31:0] n2);
        exp_t e;
        e.id = id; e.c1 = c1; e.v1 = v1; e.c2 = c2; e.v2 = v2; e.cd = cd; e.vd = vd;
        e.cc = cc; e.vc = vc; e.cn = cn; e.n1 = n1; e.n2 = n2;
        return e;
    endfunction

    task automatic cmp(input string nm, input int id, input logic [31:0] act, input logic [31:0] expv);
        n_chk++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s step=%0d got=%h expected=%h", nm, id, act, expv);
        end
    endtask

    task automatic step(input bit r, input bit w, input logic [4:0] rd, input logic [31:0] wd,
                        input logic [4:0] a1, input logic [4:0] a2, input logic [4:0] ad,
                        input bit push, input exp_t e);
        @(posedge clk);
        #1;
        rst = r; reg_write = w; rd_addr = rd; wr_data = wd;
        rs1_addr = a1; rs2_addr = a2; dbg_addr = ad;
        if (push) q.push_back(e);
    endtask

    // Monitor: one expected entry per driven cycle, checked on the falling edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                e = q.pop_front();
                if (e.c1) cmp("rs1_data", e.id, rs1_data, e.v1);
                if (e.c2) cmp("rs2_data", e.id, rs2_data, e.v2);
                if (e.cd) cmp("dbg_data", e.id, dbg_data, e.vd);
                if (e.cc) cmp("wr_count", e.id, wr_count, e.vc);
                if (e.cn) begin
                    cmp("nobyp_rs1", e.id, rs1_nb, e.n1);
                    cmp("nobyp_rs2", e.id, rs2_nb, e.n2);
                    if (e.cd) cmp("nobyp_dbg", e.id, dbg_nb, e.vd);
                    if (e.cc) cmp("nobyp_cnt", e.id, cnt_nb, e.vc);
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "bench did not complete");
    end

    logic [31:0] m [32];
    logic [31:0] mcnt;
    exp_t        none;

    initial begin
        none = ex(0, 0, '0, 0, '0, 0, '0, 0, '0, 0, '0, '0);

        // Reset and full dump through the debug port
        step(1, 0, 0, 0, 0, 0, 0, 0, none);
        for (int i = 0; i < 32; i++) begin
            step(0, 0, 0, 0, 0, 0, 5'(i), 1,
                 ex(100 + i, 1, 0, 1, 0, 1, (i == 2) ? 32'h0000_03FC : 32'h0, 1, 0, 1, 0, 0));
        end

        // Basic write then read on both ports
        step(0, 1, 5, 32'hDEAD_BEEF, 5, 0, 5, 1, ex(200, 1, 32'hDEAD_BEEF, 1, 0, 1, 0, 1, 0, 1, 0, 0));
        step(0, 0, 0, 0, 5, 5, 5, 1,
             ex(201, 1, 32'hDEAD_BEEF, 1, 32'hDEAD_BEEF, 1, 32'hDEAD_BEEF, 1, 1, 1, 32'hDEAD_BEEF, 32'hDEAD_BEEF));

        // Writes to x0 are discarded and never bypassed
        step(0, 1, 0, 32'hFFFF_FFFF, 0, 0, 0, 1, ex(300, 1, 0, 1, 0, 1, 0, 1, 1, 1, 0, 0));
        step(0, 0, 0, 0, 0, 5, 0, 1, ex(301, 1, 0, 1, 32'hDEAD_BEEF, 1, 0, 1, 1, 1, 0, 32'hDEAD_BEEF));

        // Same-cycle bypass vs committed value
        step(0, 1, 7, 32'h11, 7, 7, 7, 1, ex(400, 1, 32'h11, 1, 32'h11, 1, 0, 1, 1, 1, 0, 0));
        step(0, 1, 7, 32'h22, 7, 0, 7, 1, ex(401, 1, 32'h22, 1, 0, 1, 32'h11, 1, 2, 1, 32'h11, 0));
        step(0, 0, 0, 0, 7, 7, 7, 1, ex(402, 1, 32'h22, 1, 32'h22, 1, 32'h22, 1, 3, 1, 32'h22, 32'h22));

        // Reset beats a simultaneous write; stack pointer restored
        step(1, 1, 9, 32'h1234, 9, 5, 9, 1,
             ex(500, 1, 0, 1, 32'hDEAD_BEEF, 1, 0, 1, 3, 1, 0, 32'hDEAD_BEEF));
        step(0, 0, 0, 0, 9, 7, 9, 1, ex(501, 1, 0, 1, 0, 1, 0, 1, 0, 1, 0, 0));
        step(0, 1, 2, 32'h55, 2, 0, 2, 1,
             ex(502, 1, 32'h55, 1, 0, 1, 32'h3FC, 1, 0, 1, 32'h3FC, 0));
        step(0, 0, 0, 0, 2, 2, 2, 1, ex(503, 1, 32'h55, 1, 32'h55, 1, 32'h55, 1, 1, 1, 32'h55, 32'h55));
        step(1, 0, 0, 0, 2, 2, 2, 1, ex(504, 1, 32'h55, 1, 32'h55, 1, 32'h55, 1, 1, 1, 32'h55, 32'h55));
        step(0, 0, 0, 0, 2, 2, 2, 1,
             ex(505, 1, 32'h3FC, 1, 32'h3FC, 1, 32'h3FC, 1, 0, 1, 32'h3FC, 32'h3FC));

        // Counter wrap: preload the counter, then one more committed write
        step(0, 0, 0, 0, 0, 0, 0, 0, none);
        #2;
        force dut.wr_cnt = 32'hFFFF_FFFF;
        #1;
        release dut.wr_cnt;
        step(0, 1, 3, 32'h1, 3, 0, 3, 1, ex(600, 1, 32'h1, 1, 0, 1, 0, 1, 32'hFFFF_FFFF, 0, 0, 0));
        step(0, 0, 0, 0, 3, 0, 3, 1, ex(601, 1, 32'h1, 1, 0, 1, 32'h1, 1, 0, 0, 0, 0));

        // Random write/read traffic against a reference model
        step(1, 0, 0, 0, 0, 0, 0, 0, none);
        for (int i = 0; i < 32; i++) m[i] = (i == 2) ? 32'h0000_03FC : 32'h0;
        mcnt = 0;
        for (int k = 0; k < 400; k++) begin
            bit          w;
            logic [4:0]  rd, a1, a2, ad;
            logic [31:0] wd, v1, v2;
            w  = 1'($urandom_range(0, 1));
            rd = 5'($urandom_range(0, 31));
            wd = $urandom;
            a1 = ($urandom_range(0, 3) == 0) ? rd : 5'($urandom_range(0, 31));
            a2 = ($urandom_range(0, 3) == 0) ? rd : 5'($urandom_range(0, 31));
            ad = ($urandom_range(0, 3) == 0) ? rd : 5'($urandom_range(0, 31));
            v1 = (a1 == 0) ? 32'h0 : (w && rd != 0 && rd == a1) ? wd : m[a1];
            v2 = (a2 == 0) ? 32'h0 : (w && rd != 0 && rd == a2) ? wd : m[a2];
            step(0, w, rd, wd, a1, a2, ad, 1,
                 ex(1000 + k, 1, v1, 1, v2, 1, m[ad], 1, mcnt, 1, m[a1], m[a2]));
            if (w && rd != 0) begin
                m[rd] = wd;
                mcnt  = mcnt + 1;
            end
        end

        for (int k = 0; k < 20 && q.size() > 0; k++) @(posedge clk);
        @(negedge clk);
        #1;
        if (q.size() != 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL drain pending=%0d expected=0", q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
